bcd_to_binary_seq: RTL and testbench

Sequential BCD-to-binary converter, the inverse of the team's binary-to-decimal display path. It accepts a packed multi-digit BCD value, typically entered on SW, and produces its binary equivalent using the reverse double-dabble (shift-right / subtract-3) algorithm. One bit is processed per clock under a start/busy/done handshake. The output feeds downstream arithmetic labs and LED readback.

---
 rtl/bcd_pkg.sv | 26 ++
 rtl/bcd_digit_adj.sv | 15 +
 rtl/bcd_to_binary_seq.sv | 124 ++++++++++++
 tb/tb_bcd_to_binary_seq.sv | 122 ++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-binary converter: FSM states, digit
// adjust constants and the digit validity helper.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } bcd_state_e;

  localparam logic [3:0] BCD_ADJ       = 4'd3;
  localparam logic [3:0] BCD_ADJ_MIN   = 4'd8;
  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

  // True when any of the low `digits` nibbles of v is not a decimal digit.
  function automatic logic bcd_has_invalid(input logic [15:0] v,
                                           input int unsigned digits);
    logic bad;
    bad = 1'b0;
    for (int unsigned i = 0; i < digits; i++) begin
      if (v[4*i +: 4] > BCD_DIGIT_MAX) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble digit cell: subtracts 3 from a BCD digit that is 8 or
// more after the right shift.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = din;
    if (din >= BCD_ADJ_MIN) dout = din - BCD_ADJ;
  end

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter, one bit per clock, start/busy/done
// handshake. Define BCD_CHECK_EN to flag invalid input digits on err.
module bcd_to_binary_seq
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 2
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [4*DIGITS-1:0]   bin_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  bcd_state_e    state_q, state_d;
  logic [W-1:0]  bcd_q, bcd_d;
  logic [W-1:0]  bin_q, bin_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  bin_out_d;
  logic          busy_d, done_d;
  logic          bad_q, bad_d;
  logic          err_d;

  // {bcd_q, bin_q} shifted right by one, then every BCD digit adjusted.
  logic [W-1:0]  sh_bcd, sh_bin, adj_bcd;
  assign sh_bcd = {1'b0, bcd_q[W-1:1]};
  assign sh_bin = {bcd_q[0], bin_q[W-1:1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (sh_bcd[4*g +: 4]),
      .dout (adj_bcd[4*g +: 4])
    );
  end

`ifdef BCD_CHECK_EN
  logic err_q;
  assign err   = err_q;
  assign bad_d = (state_q == ST_IDLE && start) ?
                 bcd_has_invalid(16'(bcd_in), DIGITS) : bad_q;
`else
  assign err   = 1'b0;
  assign bad_d = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    cnt_d     = cnt_q;
    bin_out_d = bin_out;
    busy_d    = busy;
    done_d    = 1'b0;
    err_d     = err;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          bcd_d   = bcd_in;
          bin_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bcd_d = adj_bcd;
        bin_d = sh_bin;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d     = '0;
          bin_out_d = bad_q ? '0 : sh_bin;
          err_d     = bad_q;
          done_d    = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      bin_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      bin_out <= bin_out_d;
      busy    <= busy_d;
      done    <= done_d;
      bad_q   <= bad_d;
    end
  end

`ifdef BCD_CHECK_EN
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) err_q <= 1'b0;
    else         err_q <= err_d;
  end
`else
  logic unused_err_d;
  assign unused_err_d = err_d;
`endif

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Directed self-checking bench for bcd_to_binary_seq (DIGITS=2).
module tb_bcd_to_binary_seq;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       start = 1'b0;
  logic [7:0] bcd_in = '0;
  logic [7:0] bin_out;
  logic       busy, done, err;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int cyc = 0;

  bcd_to_binary_seq #(.DIGITS(2)) dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .start   (start),
    .bcd_in  (bcd_in),
    .bin_out (bin_out),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc++;
  always @(negedge Clock) if (done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one conversion, check latency, busy span, result and the drop.
  task automatic run_conv(input string tag, input logic [7:0] v,
                          input logic [7:0] exp_bin, input logic exp_err);
    int j, busy_hi;
    @(negedge Clock); bcd_in = v; start = 1'b1;
    @(posedge Clock);
    @(negedge Clock); start = 1'b0;
    j = 0; busy_hi = 0;
    while (!done && j < 20) begin
      if (busy) busy_hi++;
      @(negedge Clock); j++;
    end
    if (busy) busy_hi++;
    chk({tag, "_latency"}, j, 8);
    chk({tag, "_bin"}, bin_out, exp_bin);
    chk({tag, "_err"}, err, exp_err);
    @(negedge Clock);
    chk({tag, "_busy_cycles"}, busy_hi, 9);
    chk({tag, "_done_fall"}, {busy, done}, 2'b00);
  endtask

  initial begin
    int d0, j, last_cyc;

    #12;
    chk("reset_outputs", {bin_out, busy, done, err}, 11'h0);
    @(negedge Clock); Resetn = 1'b1;

    run_conv("c42", 8'h42, 8'h2A, 1'b0);
    run_conv("c99", 8'h99, 8'h63, 1'b0);
    run_conv("c00", 8'h00, 8'h00, 1'b0);
`ifdef BCD_CHECK_EN
    run_conv("c1A_bad", 8'h1A, 8'h00, 1'b1);
    run_conv("c15", 8'h15, 8'h0F, 1'b0);
`endif

    // Second start mid-conversion must be ignored.
    d0 = done_cnt;
    @(negedge Clock); bcd_in = 8'h42; start = 1'b1;
    @(posedge Clock);
    @(negedge Clock); start = 1'b0;
    @(negedge Clock);
    @(negedge Clock); bcd_in = 8'h99; start = 1'b1;
    @(negedge Clock); start = 1'b0;
    j = 0;
    while (!done && j < 20) begin @(negedge Clock); j++; end
    chk("restart_bin", bin_out, 8'h2A);
    repeat (14) @(negedge Clock);
    chk("restart_one_done", done_cnt - d0, 1);

    // Asynchronous reset in the middle of a conversion.
    @(negedge Clock); bcd_in = 8'h42; start = 1'b1;
    @(posedge Clock);
    @(negedge Clock); start = 1'b0;
    repeat (3) @(negedge Clock);
    d0 = done_cnt;
    #1 Resetn = 1'b0;
    #1 chk("async_reset_outputs", {bin_out, busy, done, err}, 11'h0);
    @(negedge Clock); Resetn = 1'b1;
    repeat (12) @(negedge Clock);
    chk("reset_no_done", done_cnt - d0, 0);
    chk("reset_bin_held", bin_out, 8'h00);
    run_conv("c07", 8'h07, 8'h07, 1'b0);

    // Start held high: one done every 10 cycles.
    @(negedge Clock); bcd_in = 8'h50; start = 1'b1;
    last_cyc = -1;
    for (int n = 0; n < 3; n++) begin
      j = 0;
      @(negedge Clock);
      while (!done && j < 20) begin @(negedge Clock); j++; end
      chk("held_bin", bin_out, 8'h32);
      if (n > 0) chk("held_period", cyc - last_cyc, 10);
      last_cyc = cyc;
    end
    start = 1'b0;
    repeat (12) @(negedge Clock);
    chk("held_idle", {busy, done}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
